// File: rtl/eq_pkg.sv
// Shared constants, FSM state type and saturation helper for the biquad equalizer.
package eq_pkg;

  localparam int EQ_FRAC = 16;
  localparam int ONE     = 32'sd1 << EQ_FRAC;
  localparam int SAT_IW  = 128;

  localparam logic [2:0] K_B0 = 3'd0;
  localparam logic [2:0] K_B1 = 3'd1;
  localparam logic [2:0] K_B2 = 3'd2;
  localparam logic [2:0] K_A1 = 3'd3;
  localparam logic [2:0] K_A2 = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAC  = 3'd1,
    ST_WB   = 3'd2,
    ST_SUM  = 3'd3,
    ST_DONE = 3'd4
  } eq_state_e;

  // Clamp a wide signed value into the two's complement range of w bits.
  function automatic logic signed [SAT_IW-1:0] sat(input logic signed [SAT_IW-1:0] v,
                                                   input int w);
    logic signed [SAT_IW-1:0] one_v;
    logic signed [SAT_IW-1:0] mx;
    logic signed [SAT_IW-1:0] mn;
    logic signed [SAT_IW-1:0] r;
    one_v = SAT_IW'(1'b1);
    mx    = (one_v <<< (w - 1)) - one_v;
    mn    = -mx - one_v;
    if (v > mx) begin
      r = mx;
    end else if (v < mn) begin
      r = mn;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/eq_biquad_mac.sv
// Shared multiply-accumulate for the biquad engine; y_o is the scaled, saturated accumulator.
module eq_biquad_mac
  import eq_pkg::*;
#(
  parameter int W    = 29,
  parameter int FRAC = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                clr_i,
  input  logic signed [W-1:0] coef_i,
  input  logic signed [W-1:0] opnd_i,
  output logic signed [W-1:0] y_o
);

  localparam int ACCW = 2 * W + 3;

  logic signed [2*W-1:0]    prod_s;
  logic signed [ACCW-1:0]   acc_d;
  logic signed [ACCW-1:0]   acc_q;
  logic signed [SAT_IW-1:0] wide_s;

  // Product, next accumulator value and saturating writeback value.
  always_comb begin
    prod_s = (2*W)'(coef_i) * (2*W)'(opnd_i);
    if (!en_i) begin
      acc_d = acc_q;
    end else if (clr_i) begin
      acc_d = ACCW'(prod_s);
    end else begin
      acc_d = acc_q + ACCW'(prod_s);
    end
    wide_s = SAT_IW'(acc_q >>> FRAC);
    y_o    = W'(sat(wide_s, W));
  end

  // Accumulator register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/ecualizador_param.sv
// Time-multiplexed direct-form-I equalizer: N_BANDS bands of SECTIONS biquads on one MAC.
// Define EQ_BAND_GAIN_EN for per-band gain registers applied in a multi-cycle SUM stage.
module ecualizador_param
  import eq_pkg::*;
#(
  parameter int W        = 29,
  parameter int FRAC     = EQ_FRAC,
  parameter int N_BANDS  = 3,
  parameter int SECTIONS = 2,
  parameter int AW       = 5
) (
  input  logic                 clk_i,
  input  logic                 reset,
  input  logic                 dataf_i,
  input  logic [W-1:0]         dato_i,
  output logic                 dataf_o,
  output logic [N_BANDS*W-1:0] dato_o,
  output logic [W-1:0]         dato_sum_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  input  logic                 ovr_clr_i,
  input  logic                 coef_we_i,
  input  logic [AW-1:0]        coef_addr_i,
  input  logic [W-1:0]         coef_data_i,
  output logic                 coef_ready_o
);

  localparam int NSEC  = N_BANDS * SECTIONS;
  localparam int NCOEF = NSEC * 5;
`ifdef EQ_BAND_GAIN_EN
  localparam int NREG  = NCOEF + N_BANDS;
  localparam int GBW   = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
`else
  localparam int NREG  = NCOEF;
`endif
  localparam int SECW  = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam int CIW   = $clog2(NREG);
  localparam int SW    = W + $clog2(N_BANDS) + 1;
  localparam logic signed [W-1:0] UNITY = (FRAC == EQ_FRAC) ? W'(ONE) : (W'(1'b1) << FRAC);

  eq_state_e             state_q, state_d;
  logic [SECW-1:0]       sec_q;
  logic [2:0]            k_q;
  logic signed [W-1:0]   samp_q;
  logic signed [W-1:0]   coef_q [NREG];
  logic signed [W-1:0]   x1_q [NSEC];
  logic signed [W-1:0]   x2_q [NSEC];
  logic signed [W-1:0]   y1_q [NSEC];
  logic signed [W-1:0]   y2_q [NSEC];
  logic [N_BANDS*W-1:0]  dato_q;
  logic [W-1:0]          sum_q;
  logic                  dataf_q;
  logic                  overrun_q;

  logic                  coef_wr_s;
  logic                  sec_first_s;
  logic                  sum_last_s;
  logic [CIW-1:0]        cidx_s;
  logic signed [W-1:0]   x_in_s;
  logic signed [W-1:0]   opnd_s;
  logic signed [W-1:0]   y_s;
  logic signed [SW-1:0]  sum_full_s;
`ifdef EQ_BAND_GAIN_EN
  logic [GBW-1:0]        gb_q;
  logic signed [SW-1:0]  gacc_q;
  logic signed [W-1:0]   gband_s;
  logic signed [2*W-1:0] gprod_s;
  logic signed [W-1:0]   gterm_s;
`endif

  assign busy_o       = (state_q != ST_IDLE);
  assign coef_ready_o = !busy_o;
  assign dataf_o      = dataf_q;
  assign dato_o       = dato_q;
  assign dato_sum_o   = sum_q;
  assign overrun_o    = overrun_q;

  // Datapath selects: coefficient address, section input, MAC operand and band sum.
  always_comb begin
    coef_wr_s   = coef_we_i && !busy_o && (32'(coef_addr_i) < 32'(NREG));
    sec_first_s = ((int'(sec_q) % SECTIONS) == 0);
    // Later sections take the previous section's freshly written y1.
    x_in_s      = sec_first_s ? samp_q : y1_q[sec_q - SECW'(1'b1)];
    cidx_s      = CIW'(sec_q) * CIW'(3'd5) + CIW'(k_q);
    case (k_q)
      K_B0:    opnd_s = x_in_s;
      K_B1:    opnd_s = x1_q[sec_q];
      K_B2:    opnd_s = x2_q[sec_q];
      K_A1:    opnd_s = y1_q[sec_q];
      K_A2:    opnd_s = y2_q[sec_q];
      default: opnd_s = '0;
    endcase
`ifdef EQ_BAND_GAIN_EN
    gband_s    = y1_q[SECW'(gb_q) * SECW'(SECTIONS) + SECW'(SECTIONS - 1)];
    gprod_s    = (2*W)'(gband_s) * (2*W)'(coef_q[CIW'(NCOEF) + CIW'(gb_q)]);
    gterm_s    = W'(sat(SAT_IW'(gprod_s >>> FRAC), W));
    sum_full_s = ((gb_q == '0) ? '0 : gacc_q) + SW'(gterm_s);
    sum_last_s = (int'(gb_q) == N_BANDS - 1);
`else
    sum_full_s = '0;
    for (int b = 0; b < N_BANDS; b++) begin
      sum_full_s = sum_full_s + SW'(y1_q[SECW'(b * SECTIONS + SECTIONS - 1)]);
    end
    sum_last_s = 1'b1;
`endif
  end

  eq_biquad_mac #(
    .W    (W),
    .FRAC (FRAC)
  ) u_mac (
    .clk_i  (clk_i),
    .rst_ni (reset),
    .en_i   (state_q == ST_MAC),
    .clr_i  (k_q == K_B0),
    .coef_i (coef_q[cidx_s]),
    .opnd_i (opnd_s),
    .y_o    (y_s)
  );

  // Next-state logic of the sequencing FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = dataf_i ? ST_MAC : ST_IDLE;
      ST_MAC:  state_d = (k_q == K_A2) ? ST_WB : ST_MAC;
      ST_WB:   state_d = (int'(sec_q) == NSEC - 1) ? ST_SUM : ST_MAC;
      ST_SUM:  state_d = sum_last_s ? ST_DONE : ST_SUM;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Coefficient store; reset leaves every section as a unity passthrough.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        coef_q[i] <= ((i < NCOEF) && ((i % 5) != int'(K_B0))) ? '0 : UNITY;
      end
    end else if (coef_wr_s) begin
      coef_q[CIW'(coef_addr_i)] <= coef_data_i;
    end
  end

  // Sample latch, sequencing counters, history writeback and output registers.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      samp_q  <= '0;
      sec_q   <= '0;
      k_q     <= '0;
      dato_q  <= '0;
      sum_q   <= '0;
      dataf_q <= 1'b0;
      for (int s = 0; s < NSEC; s++) begin
        x1_q[s] <= '0;
        x2_q[s] <= '0;
        y1_q[s] <= '0;
        y2_q[s] <= '0;
      end
`ifdef EQ_BAND_GAIN_EN
      gb_q    <= '0;
      gacc_q  <= '0;
`endif
    end else begin
      dataf_q <= (state_q == ST_SUM) && sum_last_s;
      case (state_q)
        ST_IDLE: begin
          if (dataf_i) begin
            samp_q <= dato_i;
            sec_q  <= '0;
            k_q    <= '0;
          end
        end
        ST_MAC: k_q <= k_q + 3'd1;
        ST_WB: begin
          x2_q[sec_q] <= x1_q[sec_q];
          x1_q[sec_q] <= x_in_s;
          y2_q[sec_q] <= y1_q[sec_q];
          y1_q[sec_q] <= y_s;
          sec_q       <= sec_q + SECW'(1'b1);
          k_q         <= '0;
        end
        ST_SUM: begin
`ifdef EQ_BAND_GAIN_EN
          gacc_q <= sum_full_s;
          gb_q   <= gb_q + GBW'(1'b1);
`endif
          if (sum_last_s) begin
            for (int b = 0; b < N_BANDS; b++) begin
              dato_q[b*W +: W] <= y1_q[SECW'(b * SECTIONS + SECTIONS - 1)];
            end
            sum_q <= W'(sat(SAT_IW'(sum_full_s), W));
`ifdef EQ_BAND_GAIN_EN
            gb_q  <= '0;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky overrun flag; a dropped sample wins over a clear in the same cycle.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else if (dataf_i && busy_o) begin
      overrun_q <= 1'b1;
    end else if (ovr_clr_i) begin
      overrun_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ecualizador_param.sv
// Scoreboard bench for ecualizador_param: stimulus queues expected outputs, a monitor checks them.
module tb_ecualizador_param;

  localparam int W   = 29;
  localparam int NB  = 3;
  localparam int AW  = 5;
  localparam int LAT = 38;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            dataf_i = 1'b0;
  logic [W-1:0]    dato_i = '0;
  logic            dataf_o;
  logic [NB*W-1:0] dato_o;
  logic [W-1:0]    dato_sum_o;
  logic            busy_o;
  logic            overrun_o;
  logic            ovr_clr_i = 1'b0;
  logic            coef_we_i = 1'b0;
  logic [AW-1:0]   coef_addr_i = '0;
  logic [W-1:0]    coef_data_i = '0;
  logic            coef_ready_o;

  typedef struct {
    logic [NB*W-1:0] bands;
    logic [W-1:0]    sum;
    int              stamp;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   out_cnt = 0;
  int   exp_cnt = 0;

  ecualizador_param dut (
    .clk_i        (clk),
    .reset        (reset),
    .dataf_i      (dataf_i),
    .dato_i       (dato_i),
    .dataf_o      (dataf_o),
    .dato_o       (dato_o),
    .dato_sum_o   (dato_sum_o),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o),
    .ovr_clr_i    (ovr_clr_i),
    .coef_we_i    (coef_we_i),
    .coef_addr_i  (coef_addr_i),
    .coef_data_i  (coef_data_i),
    .coef_ready_o (coef_ready_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: every output strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (dataf_o) begin
      out_cnt++;
      chk("expected_pending", (q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int b = 0; b < NB; b++) begin
          chk($sformatf("band%0d", b), dato_o[b*W +: W], e.bands[b*W +: W]);
        end
        chk("band_sum", dato_sum_o, e.sum);
        chk("latency", cyc - e.stamp, LAT);
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic push,
                      input logic [W-1:0] e0, input logic [W-1:0] e1,
                      input logic [W-1:0] e2, input logic [W-1:0] es);
    exp_t e;
    @(negedge clk);
    dataf_i = 1'b1;
    dato_i  = d;
    if (push) begin
      e.bands = {e2, e1, e0};
      e.sum   = es;
      e.stamp = cyc;
      q.push_back(e);
      exp_cnt++;
    end
    @(negedge clk);
    dataf_i = 1'b0;
  endtask

  task automatic wait_out();
    for (int i = 0; (i < 200) && (out_cnt < exp_cnt); i++) @(negedge clk);
    chk("output_count", out_cnt, exp_cnt);
  endtask

  task automatic xfer(input logic [W-1:0] d, input logic [W-1:0] e0,
                      input logic [W-1:0] e1, input logic [W-1:0] e2,
                      input logic [W-1:0] es);
    send(d, 1'b1, e0, e1, e2, es);
    wait_out();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    coef_we_i   = 1'b1;
    coef_addr_i = a;
    coef_data_i = d;
    @(negedge clk);
    coef_we_i   = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual %0d required %0d", cyc, 0);
    $fatal(1, "bench did not finish");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dataf_o", dataf_o, 0);
    chk("rst_dato_o_nonzero", (dato_o != '0), 0);
    chk("rst_sum", dato_sum_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_overrun", overrun_o, 0);
    chk("rst_coef_ready", coef_ready_o, 1);
    reset = 1'b1;

    // Passthrough coefficients after reset.
    xfer(29'd1000, 29'd1000, 29'd1000, 29'd1000, 29'd3000);
    chk("busy_after_done", busy_o, 0);

    // Band 0 section 0 gain 0.5.
    wr(5'd0, 29'd32768);
    xfer(29'd4000, 29'd2000, 29'd4000, 29'd4000, 29'd10000);
    for (int i = 0; i < 3; i++) xfer(29'd0, 29'd0, 29'd0, 29'd0, 29'd0);
    wr(5'd0, 29'd65536);

    // Recursive pole: a1 = +0.5 halves the output each sample.
    wr(5'd3, 29'd32768);
    xfer(29'd4096, 29'd4096, 29'd4096, 29'd4096, 29'd12288);
    xfer(29'd0, 29'd2048, 29'd0, 29'd0, 29'd2048);
    xfer(29'd0, 29'd1024, 29'd0, 29'd0, 29'd1024);
    xfer(29'd0, 29'd512, 29'd0, 29'd0, 29'd512);
    wr(5'd3, 29'd0);

    // Gain 2.0 on 2^27 saturates the band and the sum.
    wr(5'd0, 29'd131072);
    xfer(29'd134217728, 29'd268435455, 29'd134217728, 29'd134217728, 29'd268435455);
    wr(5'd0, 29'd65536);

    // Sample while busy is dropped; coefficient write while busy is ignored.
    send(29'd500, 1'b1, 29'd500, 29'd500, 29'd500, 29'd1500);
    repeat (9) @(negedge clk);
    chk("busy_mid", busy_o, 1);
    chk("coef_ready_mid", coef_ready_o, 0);
    dataf_i     = 1'b1;
    dato_i      = 29'd700;
    coef_we_i   = 1'b1;
    coef_addr_i = 5'd0;
    coef_data_i = 29'd0;
    @(negedge clk);
    dataf_i   = 1'b0;
    coef_we_i = 1'b0;
    chk("overrun_set", overrun_o, 1);
    wait_out();
    repeat (5) @(negedge clk);
    chk("single_output", out_cnt, exp_cnt);
    chk("overrun_sticky", overrun_o, 1);
    @(negedge clk);
    ovr_clr_i = 1'b1;
    @(negedge clk);
    ovr_clr_i = 1'b0;
    chk("overrun_clr", overrun_o, 0);
    wr(5'd31, 29'd0);
    xfer(29'd1000, 29'd1000, 29'd1000, 29'd1000, 29'd3000);

    // Reset mid-sample aborts processing and restores passthrough.
    wr(5'd0, 29'd32768);
    send(29'd1000, 1'b0, 29'd0, 29'd0, 29'd0, 29'd0);
    repeat (19) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_dataf_o", dataf_o, 0);
    chk("abort_dato_o_nonzero", (dato_o != '0), 0);
    chk("abort_sum", dato_sum_o, 0);
    chk("abort_busy", busy_o, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_output", out_cnt, exp_cnt);
    xfer(29'd1000, 29'd1000, 29'd1000, 29'd1000, 29'd3000);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ecualizador_param.md
Name: ecualizador_param

Overview:
- Parametrised successor to the fixed three-band, two-filters-per-band equalizer.
- A single time-multiplexed direct-form-I biquad engine serves N_BANDS parallel bands, each a cascade of SECTIONS biquads.
- Coefficients are runtime-loadable instead of hard-wired; outputs are per-band and a saturated band sum.
- Sits between the audio ADC sample strobe and the DAC/mixer path.

Parameters:
- W, 29, sample/coefficient width (two's complement).
- FRAC, 16, coefficient fractional bits (1.0 = 2^FRAC).
- N_BANDS, 3, number of parallel bands.
- SECTIONS, 2, cascaded biquads per band.
- AW, 5, coefficient address width; must satisfy 2^AW >= N_BANDS*SECTIONS*5.

Ports:
- clk_i  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- dataf_i  in  1  one-cycle input sample strobe.
- dato_i  in  W  input sample; valid with dataf_i.
- dataf_o  out  1  one-cycle output-valid strobe.
- dato_o  out  N_BANDS*W  band outputs; band b at [b*W +: W].
- dato_sum_o  out  W  saturated sum of all bands.
- busy_o  out  1  engine processing a sample.
- overrun_o  out  1  sticky flag: a sample was dropped.
- ovr_clr_i  in  1  clears overrun_o.
- coef_we_i  in  1  coefficient write enable.
- coef_addr_i  in  AW  address = (band*SECTIONS + section)*5 + k; k: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
- coef_data_i  in  W  coefficient value.
- coef_ready_o  out  1  high when writes are accepted (= !busy_o).

Behaviour:
- Reset (reset=0, async): all outputs 0; all x1/x2/y1/y2 history cleared; FSM to IDLE.
- Coefficient reset values: b0 = 2^FRAC, all other coefficients 0 (every section passthrough).
- Section equation: acc = b0*x + b1*x1 + b2*x2 + a1*y1 + a2*y2.
  - a-terms are added; a1/a2 are stored pre-negated.
  - Accumulator width 2W+3.
  - y = acc >>> FRAC (arithmetic shift, truncation), then saturated to W bits: max 2^(W-1)-1, min -2^(W-1).
  - History updates: x2<=x1, x1<=x, y2<=y1, y1<=y. Saturated y is stored in the history.
- Cascade: input to section s+1 of a band is y of section s. Section 0 of every band takes the latched dato_i.
- FSM:
  - IDLE: on dataf_i, latch dato_i -> MAC.
  - MAC: 5 cycles, one product per cycle -> WB.
  - WB: 1 cycle, saturate and write history. Next section -> MAC; after the last section -> SUM.
  - SUM: 1 cycle, sign-extended add of the N_BANDS band outputs, saturate to W; register dato_o and dato_sum_o -> DONE.
  - DONE: dataf_o=1 for one cycle -> IDLE.
- Latency from the dataf_i cycle to the dataf_o cycle: N_BANDS*SECTIONS*6 + 2 (38 at defaults).
- busy_o is high from the cycle after dataf_i through DONE.
- dato_o and dato_sum_o hold their values until the next DONE.
- dataf_i while busy_o=1: sample dropped, overrun_o<=1, engine state unaffected.
- overrun_o: set has priority over ovr_clr_i in the same cycle.
- coef_we_i with coef_ready_o=0, or with an address >= N_BANDS*SECTIONS*5: ignored, no side effect.
- dataf_i in the same cycle as an accepted coef write: the write completes first; the sample uses the new coefficient.
- Reset asserted mid-sample: processing aborted; no dataf_o; coefficients return to passthrough.

Optional Feature:
- Macro: EQ_BAND_GAIN_EN.
- When defined:
  - Adds per-band gain registers (reset value 2^FRAC), addressed at N_BANDS*SECTIONS*5 + band.
  - SUM stage becomes N_BANDS cycles: each band is multiplied by its gain, >>>FRAC, saturated, then accumulated.
  - Latency grows by N_BANDS-1.
  - dato_o stays the ungained band output.
- When undefined: unit gain, single-cycle SUM; writes to gain addresses are ignored.

Decomposition:
- Package eq_pkg holds:
  - coefficient index constants (K_B0..K_A2);
  - FSM state enum;
  - sat function (width-generic saturate);
  - ONE constant (2^FRAC).
- One sub-module, eq_biquad_mac: shared multiplier/accumulator with clear, accumulate and saturating writeback.
- The top holds the FSM, coefficient RAM, history RAM and summer.

Test Plan:
- Passthrough at reset: dato_i=1000 strobe -> after 38 cycles dataf_o=1, each band=1000, dato_sum_o=3000, busy_o back low.
- Band 0 section 0 b0=32768 (0.5), others unchanged; impulse 4000 then three samples of 0 -> band 0 sequence 2000,0,0,0; bands 1/2 sequence 4000,0,0,0.
- Band 0 section 0 a1=32768 (stored pre-negated), impulse 4096 -> band 0 outputs 4096,2048,1024,512 on successive samples.
- Band 0 section 0 b0=131072 (2.0), dato_i=2^27 -> band 0 = 268435455; dato_sum_o=268435455 (saturated).
- Second dataf_i 10 cycles after the first -> overrun_o=1, only one dataf_o; ovr_clr_i pulse -> overrun_o=0. coef_we_i while busy -> read-back behaviour unchanged.
- Assert reset at cycle 20 of processing -> no dataf_o; all outputs 0; next sample 1000 -> bands 1000 (history and coefficients cleared).
